// File: rtl/add_sched_pkg.sv
// ============================================================================
// add_sched_pkg: shared defaults, FSM state type and id-width helper. Rev 1.0
// ============================================================================
`default_nettype none

package add_sched_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_DATA_W  = 6;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_sched_if.sv
// ============================================================================
// add_sched_if: request/result bus of the shared-adder scheduler. Rev 1.0
// ============================================================================
`default_nettype none

interface add_sched_if
  import add_sched_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = DEFAULT_DATA_W
) ();

  localparam int c_ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_sum;
  logic                      out_flag;
  logic [c_ID_W-1:0]         out_id;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_sum, out_flag, out_id
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_sum, out_flag, out_id
  );

endinterface

`default_nettype wire

// File: rtl/add_sched_rr_arbiter.sv
// ============================================================================
// rr_arbiter: one-hot round-robin grant, search ascending from ptr with wrap.
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  wire logic [N-1:0]    req_i,
  input  wire logic [ID_W-1:0] ptr_i,
  input  wire logic            en_i,
  output logic      [N-1:0]    gnt_o
);

  localparam int                c_SW = ID_W + 1;
  localparam logic [c_SW-1:0]   c_N  = c_SW'(N);

  logic [c_SW-1:0] w_pos;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = {1'b0, ptr_i} + c_SW'(i);
      if (w_pos >= c_N) begin
        w_pos = w_pos - c_N;
      end
      w_idx = w_pos[ID_W-1:0];
      if (en_i && !w_found && req_i[w_idx]) begin
        gnt_o[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/add_sched.sv
// ============================================================================
// add_sched: round-robin scheduler sharing one registered adder among NUM_REQ
// requesters. Define ADD_SCHED_SAT_EN for signed saturating add. Rev 1.0
// ============================================================================
`default_nettype none

module add_sched
  import add_sched_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input wire logic   clk,
  input wire logic   rst_n,
  add_sched_if.slave bus
);

  localparam int c_ID_W = id_w(NUM_REQ);

  state_e              state_q, state_d;
  logic [c_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   sum_q;
  logic                flag_q;
  logic [c_ID_W-1:0]   id_q;

  logic                w_slot_free;
  logic                w_en;
  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_xfer;
  logic [c_ID_W-1:0]   w_g;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_sum;
  logic                w_flag;

  assign w_slot_free = (state_q == ST_EMPTY) || bus.out_ready;
  // Grants are suppressed while reset is asserted, not just after the edge.
  assign w_en        = w_slot_free && rst_n;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (c_ID_W)
  ) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (w_en),
    .gnt_o (w_gnt)
  );

  assign bus.req_ready = w_gnt;
  assign w_xfer        = |(bus.req_valid & w_gnt);

  always_comb begin
    w_g = '0;
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_g = c_ID_W'(i);
        w_a = bus.req_a[i*DATA_W +: DATA_W];
        w_b = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef ADD_SCHED_SAT_EN
  logic [DATA_W-1:0] w_wsum;
  logic              w_ovf;

  assign w_wsum = w_a + w_b;
  // Signed overflow: operands agree in sign but the result does not.
  assign w_ovf  = (w_a[DATA_W-1] == w_b[DATA_W-1]) &&
                  (w_wsum[DATA_W-1] != w_a[DATA_W-1]);
  assign w_sum  = !w_ovf        ? w_wsum :
                  w_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                  {1'b0, {(DATA_W-1){1'b1}}};
  assign w_flag = w_ovf;
`else
  logic [DATA_W:0] w_raw;

  assign w_raw  = {1'b0, w_a} + {1'b0, w_b};
  assign w_sum  = w_raw[DATA_W-1:0];
  assign w_flag = w_raw[DATA_W];
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (w_xfer) begin
      rr_ptr_d = (w_g == c_ID_W'(NUM_REQ - 1)) ? '0 : w_g + 1'b1;
    end
    case (state_q)
      ST_EMPTY: if (w_xfer) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready && !w_xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      flag_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (w_xfer) begin
        sum_q  <= w_sum;
        flag_q <= w_flag;
        id_q   <= w_g;
      end
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_sum   = sum_q;
  assign bus.out_flag  = flag_q;
  assign bus.out_id    = id_q;

endmodule

`default_nettype wire

// File: tb/tb_add_sched.sv
// ============================================================================
// tb_add_sched: scoreboard bench for add_sched (honours ADD_SCHED_SAT_EN).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_add_sched;

  localparam int N = 4;
  localparam int W = 6;
  localparam int MOD = 1 << W;

  typedef struct {
    int id;
    int sum;
    int flag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];
  int   m_full;
  int   m_ptr;

  add_sched_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  add_sched #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int id, input int a, input int b);
    exp_t e;
    int   sa, sbv, s;
    e.id = id;
`ifdef ADD_SCHED_SAT_EN
    sa  = (a >= MOD / 2) ? a - MOD : a;
    sbv = (b >= MOD / 2) ? b - MOD : b;
    s   = sa + sbv;
    if (s > MOD / 2 - 1) begin
      e.sum = MOD / 2 - 1; e.flag = 1;
    end else if (s < -MOD / 2) begin
      e.sum = MOD / 2;     e.flag = 1;
    end else begin
      e.sum = (s + MOD) % MOD; e.flag = 0;
    end
`else
    sa  = a;
    sbv = b;
    s   = sa + sbv;
    e.sum  = s % MOD;
    e.flag = (s >= MOD) ? 1 : 0;
`endif
    return e;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*W +: W] = W'(a);
    bus.req_b[i*W +: W] = W'(b);
  endtask

  // Reference model: predicts grant and result for the coming rising edge.
  always @(negedge clk) begin
    int   g, idx, a, b;
    exp_t e;
    if (!rst_n) begin
      m_full = 0;
      m_ptr  = 0;
      sb.delete();
      chk("rst_ready", int'(bus.req_ready), 0);
      chk("rst_valid", int'(bus.out_valid), 0);
    end else begin
      chk("valid", int'(bus.out_valid), m_full);
      if (m_full != 0) begin
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
          chk("sum",  int'(bus.out_sum),  sb[0].sum);
          chk("flag", int'(bus.out_flag), sb[0].flag);
          chk("id",   int'(bus.out_id),   sb[0].id);
        end
      end
      g = -1;
      if (m_full == 0 || bus.out_ready) begin
        for (int i = 0; i < N; i++) begin
          idx = (m_ptr + i) % N;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      chk("ready", int'(bus.req_ready), (g >= 0) ? (1 << g) : 0);
      if (m_full != 0 && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (g >= 0) begin
        a = int'(bus.req_a[g*W +: W]);
        b = int'(bus.req_b[g*W +: W]);
        e = model(g, a, b);
        sb.push_back(e);
        m_ptr  = (g + 1) % N;
        m_full = 1;
      end else if (bus.out_ready) begin
        m_full = 0;
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_sum",   int'(bus.out_sum),   0);
    chk("reset_flag",  int'(bus.out_flag),  0);
    chk("reset_id",    int'(bus.out_id),    0);
    chk("reset_ready", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = '0;

    // Single add 5+3 from requester 0
    @(posedge clk); #1;
    bus.req_valid = 4'b0001; set_op(0, 5, 3); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("first_valid", int'(bus.out_valid), 1);
    chk("first_sum",   int'(bus.out_sum),   8);
    chk("first_id",    int'(bus.out_id),    0);
    chk("first_flag",  int'(bus.out_flag),  0);
    @(posedge clk); #1;
    apply_reset();

    // All requesters active: strict rotation, one result per cycle
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i, i + 1, 2 * i);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_gnt", int'(bus.req_ready), 1 << (k % N));
      if (k > 0) chk("rr_valid", int'(bus.out_valid), 1);
    end

    // Stall three cycles, then back-to-back consume + grant
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", int'(bus.req_ready), 0);
      chk("stall_valid", int'(bus.out_valid), 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    #1;
    chk("b2b_gnt",   int'(bus.req_ready), 4'b0010);
    chk("b2b_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    chk("b2b_id",  int'(bus.out_id),  1);
    chk("b2b_sum", int'(bus.out_sum), 4);

    // Overflow boundaries on requester 2
    bus.req_valid = 4'b0100; set_op(2, 63, 1);
    @(posedge clk); #1;
    e = model(2, 63, 1);
    chk("ovf1_sum", int'(bus.out_sum), e.sum);
    chk("ovf1_flag", int'(bus.out_flag), e.flag);
`ifndef ADD_SCHED_SAT_EN
    chk("wrap_sum_const",  int'(bus.out_sum),  0);
    chk("wrap_flag_const", int'(bus.out_flag), 1);
`endif
    set_op(2, 31, 1);
    @(posedge clk); #1;
`ifdef ADD_SCHED_SAT_EN
    chk("sat_pos_sum",  int'(bus.out_sum),  31);
    chk("sat_pos_flag", int'(bus.out_flag), 1);
`else
    chk("wrap31_sum",  int'(bus.out_sum),  32);
    chk("wrap31_flag", int'(bus.out_flag), 0);
`endif
    set_op(2, 32, 63);
    @(posedge clk); #1;
`ifdef ADD_SCHED_SAT_EN
    chk("sat_neg_sum",  int'(bus.out_sum),  32);
    chk("sat_neg_flag", int'(bus.out_flag), 1);
`else
    chk("wrap32_sum",  int'(bus.out_sum),  31);
    chk("wrap32_flag", int'(bus.out_flag), 1);
`endif
    bus.req_valid = '0;

    // Random traffic against the reference model
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      bus.req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, int'($urandom_range(0, MOD - 1)),
                                        int'($urandom_range(0, MOD - 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Asynchronous reset while FULL
    @(posedge clk); #1;
    bus.req_valid = '0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 4'b0010; set_op(1, 7, 7); bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 4'b1010;
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    #2;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(bus.out_valid), 0);
    chk("async_sum",   int'(bus.out_sum),   0);
    chk("async_ready", int'(bus.req_ready), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt", int'(bus.req_ready), 4'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
